// File: rtl/contador_programa_pkg.sv
// +--------------------------------------------------------------------------
// | contador_programa_pkg : action encoding and default constants for the PC
// | rev 1.0
// +--------------------------------------------------------------------------
`default_nettype none

package contador_programa_pkg;

  localparam int c_LARGURA_PADRAO   = 32;
  localparam int c_PROF_PILHA_PADRAO = 8;
  localparam int c_END_RESET_PADRAO = 0;
  localparam int c_PASSO_PADRAO     = 1;

  // Declaration order is the priority order, highest first.
  typedef enum logic [2:0] {
    ACAO_RESET  = 3'd0,
    ACAO_CALL   = 3'd1,
    ACAO_RET    = 3'd2,
    ACAO_JUMP   = 3'd3,
    ACAO_BRANCH = 3'd4,
    ACAO_HALT   = 3'd5,
    ACAO_INC    = 3'd6
  } acao_t;

  function automatic acao_t seleciona_acao(input logic reseta, input logic call,
                                           input logic ret, input logic jump,
                                           input logic branch, input logic halt);
    if (reseta)      return ACAO_RESET;
    else if (call)   return ACAO_CALL;
    else if (ret)    return ACAO_RET;
    else if (jump)   return ACAO_JUMP;
    else if (branch) return ACAO_BRANCH;
    else if (halt)   return ACAO_HALT;
    else             return ACAO_INC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/contador_programa_pilha_retorno.sv
// +--------------------------------------------------------------------------
// | pilha_retorno : LIFO return-address stack with occupancy counter
// | rev 1.0
// +--------------------------------------------------------------------------
`default_nettype none

module pilha_retorno
  import contador_programa_pkg::*;
#(
  parameter int LARGURA    = c_LARGURA_PADRAO,
  parameter int PROF_PILHA = c_PROF_PILHA_PADRAO
) (
  input  logic               clock,
  input  logic               reseta,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dado_in,
  output logic [LARGURA-1:0] topo,
  output logic               cheia,
  output logic               vazia
);

  localparam int c_IW = $clog2(PROF_PILHA);

  logic [LARGURA-1:0] r_mem [PROF_PILHA];
  logic [c_IW:0]      r_ocup;
  logic [c_IW-1:0]    w_idx_topo;

  assign w_idx_topo = r_ocup[c_IW-1:0] - c_IW'(1);
  assign topo       = r_mem[w_idx_topo];
  assign cheia      = (r_ocup == (c_IW+1)'(PROF_PILHA));
  assign vazia      = (r_ocup == '0);

  // Callers only push when not full and pop when not empty.
  always_ff @(posedge clock) begin
    if (reseta) begin
      r_ocup <= '0;
    end else if (push) begin
      r_ocup <= r_ocup + 1'b1;
    end else if (pop) begin
      r_ocup <= r_ocup - 1'b1;
    end
  end

  // Contents survive reset; only the occupancy is discarded.
  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_ocup[c_IW-1:0]] <= dado_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/contador_programa.sv
// +--------------------------------------------------------------------------
// | contador_programa : program counter with jump/branch/call/ret and halt
// | rev 1.0
// +--------------------------------------------------------------------------
`default_nettype none

module contador_programa
  import contador_programa_pkg::*;
#(
  parameter int                 LARGURA    = c_LARGURA_PADRAO,
  parameter int                 PROF_PILHA = c_PROF_PILHA_PADRAO,
  parameter logic [LARGURA-1:0] END_RESET  = LARGURA'(c_END_RESET_PADRAO),
  parameter logic [LARGURA-1:0] PASSO      = LARGURA'(c_PASSO_PADRAO)
) (
  input  logic               clock,
  input  logic               reseta,
  input  logic               halt,
  input  logic               jump,
  input  logic               branch,
  input  logic               call,
  input  logic               ret,
  input  logic [LARGURA-1:0] endereco,
  input  logic [LARGURA-1:0] deslocamento,
  output logic [LARGURA-1:0] saida,
  output logic               pilha_cheia,
  output logic               pilha_vazia,
  output logic               erro
);

  logic [LARGURA-1:0] r_saida = END_RESET;
  logic               r_erro;
  acao_t              w_acao;
  logic [LARGURA-1:0] w_proximo;
  logic [LARGURA-1:0] w_retorno;
  logic [LARGURA-1:0] w_topo;
  logic               w_push;
  logic               w_pop;
  logic               w_erro_set;

  pilha_retorno #(
    .LARGURA    (LARGURA),
    .PROF_PILHA (PROF_PILHA)
  ) u_pilha (
    .clock   (clock),
    .reseta  (reseta),
    .push    (w_push),
    .pop     (w_pop),
    .dado_in (w_retorno),
    .topo    (w_topo),
    .cheia   (pilha_cheia),
    .vazia   (pilha_vazia)
  );

  always_comb begin
    w_acao     = seleciona_acao(reseta, call, ret, jump, branch, halt);
    w_retorno  = r_saida + PASSO;
    w_proximo  = r_saida;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_erro_set = 1'b0;
    case (w_acao)
      ACAO_RESET:  w_proximo = END_RESET;
      ACAO_CALL: begin
        if (pilha_cheia) begin
          w_erro_set = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_proximo = endereco;
        end
      end
      ACAO_RET: begin
        if (pilha_vazia) begin
          w_erro_set = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_proximo = w_topo;
        end
      end
      ACAO_JUMP:   w_proximo = endereco;
      ACAO_BRANCH: w_proximo = r_saida + deslocamento;
      ACAO_HALT:   w_proximo = r_saida;
      ACAO_INC:    w_proximo = w_retorno;
      default:     w_proximo = r_saida;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reseta) begin
      r_saida <= END_RESET;
      r_erro  <= 1'b0;
    end else begin
      r_saida <= w_proximo;
      if (w_erro_set) begin
        r_erro <= 1'b1;
      end
    end
  end

  assign saida = r_saida;
  assign erro  = r_erro;

endmodule

`default_nettype wire

// File: doc/contador_programa.md
CONTADOR_PROGRAMA -- requirements
Module: contador_programa

Interface
REQ-001 SHALL have parameter LARGURA, default 32, address width in bits.
REQ-002 SHALL have parameter PROF_PILHA, default 8, return-stack depth in entries (power of two, >=2).
REQ-003 SHALL have parameter END_RESET, default 0, value loaded into saida on reset.
REQ-004 SHALL have parameter PASSO, default 1, sequential increment (word-addressed).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  sole clock; all state updates on rising edge.
REQ-007 reseta  in  1  synchronous active-high reset.
REQ-008 halt  in  1  hold saida (HLT loop).
REQ-009 jump  in  1  absolute jump to endereco.
REQ-010 branch  in  1  relative branch by deslocamento.
REQ-011 call  in  1  push return address, jump to endereco.
REQ-012 ret  in  1  pop return address into saida.
REQ-013 endereco  in  LARGURA  absolute target.
REQ-014 deslocamento  in  LARGURA  two's-complement branch offset.
REQ-015 saida  out  LARGURA  current program counter.
REQ-016 pilha_cheia  out  1  stack holds PROF_PILHA entries.
REQ-017 pilha_vazia  out  1  stack holds 0 entries.
REQ-018 erro  out  1  sticky overflow/underflow flag.

Function
REQ-019 Per edge, SHALL apply exactly one action, priority: reseta > call > ret > jump > branch > halt > increment.
REQ-020 Increment SHALL set saida <= saida + PASSO, modulo 2^LARGURA (wrap, no flag).
REQ-021 jump SHALL set saida <= endereco.
REQ-022 branch SHALL set saida <= saida + deslocamento, modulo 2^LARGURA.
REQ-023 call (not full) SHALL push saida + PASSO (modulo) and set saida <= endereco in the same edge.
REQ-024 ret (not empty) SHALL set saida <= top entry and pop it in the same edge.
REQ-025 call while pilha_cheia SHALL leave stack and saida unchanged and set erro.
REQ-026 ret while pilha_vazia SHALL leave saida unchanged and set erro.
REQ-027 halt SHALL override increment only; jump/branch/call/ret while halt SHALL still act.
REQ-028 Control-flow latency SHALL be one cycle: new saida visible after the triggering edge.
REQ-029 Stack occupancy counter SHALL range 0..PROF_PILHA; pilha_cheia/pilha_vazia SHALL be combinational decodes of it.
REQ-030 erro SHALL remain set until reseta.
REQ-031 Lower-priority simultaneous inputs SHALL be ignored with no side effect on stack or erro.

Reset
REQ-032 On reseta: saida = END_RESET, occupancy = 0, pilha_vazia = 1, pilha_cheia = 0, erro = 0.
REQ-033 reseta mid-sequence (including same edge as call/ret) SHALL discard the stack; stack contents need not be cleared.
REQ-034 Before first reset, the initial value of saida SHALL be END_RESET.

Structure
REQ-035 Shared package SHALL hold the action-priority encoding (enum ACAO_*: RESET, CALL, RET, JUMP, BRANCH, HALT, INC) and default parameter constants.
REQ-036 LIFO storage SHALL be one sub-module pilha_retorno (push, pop, dado_in, topo, cheia, vazia), parameterised by LARGURA and PROF_PILHA.
REQ-037 Action select and next-PC mux SHALL live in contador_programa.

Verification
REQ-038 reseta 1 cycle, then 5 idle edges -> saida 0,1,2,3,4,5; halt held 3 edges at 5 -> saida stays 5.
REQ-039 At saida=10, call endereco=100; 2 edges; ret -> saida 100,101,102, then 11; pilha_vazia=1, erro=0.
REQ-040 PROF_PILHA=8: 9 consecutive calls -> 8th sets pilha_cheia; 9th leaves saida/stack unchanged, erro=1 until reseta.
REQ-041 ret with empty stack at saida=7 -> saida 7 held, erro=1; then reseta -> saida 0, erro=0.
REQ-042 saida=0xFFFFFFFF idle edge -> 0; saida=20 branch deslocamento=0xFFFFFFFB -> 15.
REQ-043 call+jump+halt same edge at saida=3, endereco=40 -> saida 40, return 4 pushed; reseta+call same edge -> saida 0, pilha_vazia=1.
